// File: rtl/gol_pkg.sv
// gol_pkg: shared FSM states, default grid sizes and cell indexing for the Game-of-Life sequencer
package gol_pkg;
    localparam int GOL_ROWS  = 4;
    localparam int GOL_COLS  = 4;
    localparam int GOL_GEN_W = 8;

    typedef enum logic [1:0] {GOL_IDLE, GOL_LOAD, GOL_RUN, GOL_DONE} gol_state_e;

    function automatic int gol_cell_idx(input int row, input int col);
        return row * GOL_COLS + col;
    endfunction
endpackage

// File: rtl/gol_popcount.sv
// gol_popcount: combinational live-cell count of a W-bit grid vector
module gol_popcount #(
    parameter int W = 16
) (
    input  logic [W-1:0]             bits,
    output logic [$clog2(W+1)-1:0]   count
);
    localparam int CW = $clog2(W + 1);
    // sum every cell bit; synthesis balances the additions into a tree
    always_comb begin
        count = '0;
        for (int i = 0; i < W; i++) count = count + CW'(bits[i]);
    end
endmodule

// File: rtl/gol_gen_ctrl.sv
// gol_gen_ctrl: seeds the cell array, issues one tick per generation and reports end-of-run cause (optional GOL_GEN_CTRL_STABLE_DETECT_EN adds still-life stop)
module gol_gen_ctrl
    import gol_pkg::*;
#(
    parameter int ROWS  = GOL_ROWS,
    parameter int COLS  = GOL_COLS,
    parameter int GEN_W = GOL_GEN_W
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             start,
    input  logic                             pause,
    input  logic                             step,
    input  logic [GEN_W-1:0]                 genLimit,
    input  logic [ROWS*COLS-1:0]             seed,
    input  logic [ROWS*COLS-1:0]             gridState,
    output logic                             loadEn,
    output logic                             tickEn,
    output logic                             busy,
    output logic                             done,
    output logic [GEN_W-1:0]                 genCount,
    output logic [$clog2(ROWS*COLS+1)-1:0]   population,
    output logic                             extinct,
    output logic                             stable
);
    localparam int N  = ROWS * COLS;
    localparam int PW = $clog2(N + 1);

    gol_state_e       state, state_n;
    logic [GEN_W-1:0] gen_limit_q;
    logic [PW-1:0]    pop;
    logic             run, accept, empty, same, at_limit, end_run;

    gol_popcount #(.W(N)) u_pop (.bits(gridState), .count(pop));

`ifdef GOL_GEN_CTRL_STABLE_DETECT_EN
    logic [N-1:0] prev_grid;
    logic         stable_q;
    assign same   = (genCount != '0) && (gridState == prev_grid);
    assign stable = stable_q;
    // remember the generation just ticked away from and flag a still-life stop
    always_ff @(posedge clk) begin
        if (reset) begin
            prev_grid <= '0;
            stable_q  <= 1'b0;
        end else begin
            if (tickEn) prev_grid <= gridState;
            if (accept) stable_q <= 1'b0;
            else if (run && !empty && same) stable_q <= 1'b1;
        end
    end
`else
    assign same   = 1'b0;
    assign stable = 1'b0;
`endif

    // next-state and strobes decoded from state and this cycle's grid
    always_comb begin
        run      = state == GOL_RUN;
        accept   = state == GOL_IDLE && start;
        empty    = gridState == '0;
        at_limit = genCount == gen_limit_q;
        end_run  = run && (empty || same || at_limit);
        loadEn   = state == GOL_LOAD;
        busy     = state == GOL_LOAD || run;
        done     = state == GOL_DONE;
        tickEn   = run && !end_run && (!pause || step);
        state_n  = state == GOL_IDLE ? (start ? GOL_LOAD : GOL_IDLE) :
                   state == GOL_LOAD ? GOL_RUN :
                   run               ? (end_run ? GOL_DONE : GOL_RUN) : GOL_IDLE;
    end

    // state, generation bookkeeping, extinction flag and registered population
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= GOL_IDLE;
            gen_limit_q <= '0;
            genCount    <= '0;
            extinct     <= 1'b0;
            population  <= '0;
        end else begin
            state      <= state_n;
            population <= pop;
            if (accept) begin
                gen_limit_q <= genLimit;
                genCount    <= '0;
                extinct     <= 1'b0;
            end else begin
                if (tickEn) genCount <= genCount + GEN_W'(1);
                if (run && empty) extinct <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_gol_gen_ctrl.sv
// tb_gol_gen_ctrl: directed runs of the sequencer against a behavioural 4x4 Life array and a result scoreboard
module tb_gol_gen_ctrl;
    import gol_pkg::*;

    localparam int N = GOL_ROWS * GOL_COLS;
    localparam logic [N-1:0] BLINK = 16'h0070;
    localparam logic [N-1:0] BLOCK = 16'h0660;

    typedef struct {
        int gen;
        bit ext;
        bit stab;
        int ticks;
        int pop;
    } exp_t;

    logic clk = 1'b0, reset = 1'b1, start = 1'b0, pause = 1'b0, step = 1'b0;
    logic [7:0]   genLimit = '0;
    logic [N-1:0] seed = '0, grid = '0;
    logic loadEn, tickEn, busy, done, extinct, stable;
    logic [7:0] genCount;
    logic [4:0] population;

    int   checks = 0, failures = 0, tick_cnt = 0, done_cnt = 0;
    exp_t sb[$];

    gol_gen_ctrl dut (
        .clk(clk), .reset(reset), .start(start), .pause(pause), .step(step),
        .genLimit(genLimit), .seed(seed), .gridState(grid),
        .loadEn(loadEn), .tickEn(tickEn), .busy(busy), .done(done),
        .genCount(genCount), .population(population),
        .extinct(extinct), .stable(stable)
    );

    always #5 clk = ~clk;

    function automatic logic [N-1:0] life(input logic [N-1:0] g);
        logic [N-1:0] r = '0;
        for (int row = 0; row < GOL_ROWS; row++) begin
            for (int col = 0; col < GOL_COLS; col++) begin
                int n = 0;
                for (int dr = -1; dr <= 1; dr++)
                    for (int dc = -1; dc <= 1; dc++)
                        if ((dr != 0 || dc != 0) && row + dr >= 0 && row + dr < GOL_ROWS &&
                            col + dc >= 0 && col + dc < GOL_COLS)
                            n += int'(g[gol_cell_idx(row + dr, col + dc)]);
                r[gol_cell_idx(row, col)] = (n == 3) || (g[gol_cell_idx(row, col)] && n == 2);
            end
        end
        return r;
    endfunction

    // behavioural cell array: loads or advances on the controller strobes
    always @(posedge clk) begin
        if (loadEn) grid <= seed;
        else if (tickEn) grid <= life(grid);
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // scoreboard: every done pulse retires the oldest expected run result
    always @(negedge clk) begin
        if (loadEn) tick_cnt = 0;
        if (tickEn) tick_cnt++;
        if (done) begin
            exp_t e;
            done_cnt++;
            if (sb.size() == 0) check("sb_unexpected_done", 1, 0);
            else begin
                e = sb.pop_front();
                check("sb_genCount", genCount, e.gen);
                check("sb_extinct", extinct, e.ext);
                check("sb_stable", stable, e.stab);
                check("sb_ticks", tick_cnt, e.ticks);
                check("sb_population", population, e.pop);
            end
        end
    end

    task automatic wait_done(output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!done && lat < 200);
        if (!done) check("done_timeout", 0, 1);
    endtask

    task automatic run(input string tag, input logic [N-1:0] s, input logic [7:0] lim, input exp_t e, input int elat);
        int lat;
        sb.push_back(e);
        seed = s;
        genLimit = lim;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done(lat);
        check({tag, "_latency"}, lat, elat);
        @(negedge clk);
        check({tag, "_idle"}, busy, 0);
    endtask

    initial begin
        int lat, d0;
        bit hit;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_genCount", genCount, 0);
        check("rst_population", population, 0);
        check("rst_flags", {extinct, stable, loadEn, tickEn}, 0);

        run("empty", '0, 8'd5, '{0, 1'b1, 1'b0, 0, 0}, 3);
        run("blink", BLINK, 8'd5, '{5, 1'b0, 1'b0, 5, 3}, 8);
        run("limit0", BLINK, 8'd0, '{0, 1'b0, 1'b0, 0, 3}, 3);
`ifdef GOL_GEN_CTRL_STABLE_DETECT_EN
        run("block", BLOCK, 8'd10, '{1, 1'b0, 1'b1, 1, 4}, 4);
`else
        run("block", BLOCK, 8'd10, '{10, 1'b0, 1'b0, 10, 4}, 13);
`endif

        // paused run advances only on step pulses
        sb.push_back('{5, 1'b0, 1'b0, 5, 3});
        pause = 1'b1;
        seed = BLINK;
        genLimit = 8'd5;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (8) @(negedge clk);
        check("pause_hold_gen", genCount, 0);
        check("pause_hold_ticks", tick_cnt, 0);
        @(posedge clk);
        #1 step = 1'b1;
        @(posedge clk);
        #1 step = 1'b0;
        @(negedge clk);
        check("step1_gen", genCount, 1);
        repeat (3) @(negedge clk);
        check("step1_hold", genCount, 1);
        @(posedge clk);
        #1 step = 1'b1;
        @(posedge clk);
        #1 step = 1'b0;
        @(negedge clk);
        check("step2_gen", genCount, 2);
        check("step2_ticks", tick_cnt, 2);
        pause = 1'b0;
        wait_done(lat);
        @(negedge clk);

        // reset in the middle of a run
        d0 = done_cnt;
        seed = BLINK;
        genLimit = 8'd10;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        hit = 1'b0;
        for (int i = 0; i < 50 && !hit; i++) begin
            @(negedge clk);
            hit = genCount == 8'd3;
        end
        check("midrst_reached", hit, 1);
        reset = 1'b1;
        @(negedge clk);
        check("midrst_genCount", genCount, 0);
        check("midrst_busy", busy, 0);
        check("midrst_outs", {done, loadEn, tickEn, extinct, stable}, 0);
        check("midrst_population", population, 0);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check("midrst_no_done", done_cnt, d0);
        run("after_rst", BLINK, 8'd2, '{2, 1'b0, 1'b0, 2, 3}, 5);

        // start while busy is ignored and genLimit is not re-sampled
        sb.push_back('{3, 1'b0, 1'b0, 3, 3});
        seed = BLINK;
        genLimit = 8'd3;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (3) @(negedge clk);
        genLimit = 8'd9;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(lat);
        @(negedge clk);
        check("busy_start_idle", busy, 0);
        check("sb_drained", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
